// File: rtl/ysyx_22040759_ms_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_ms_pkg
// Shared definitions for the memory-access (MS) stage:
//   - bus widths of es_to_ms_bus (237) and ms_to_ws_bus (232)
//   - packed bundle layouts, which fix every field offset, MSB first
//   - write-back source select codes and mem_size encodings
//   - MS FSM state codes
//   - size_mask(): byte-enable mask of an access size before alignment
// ----------------------------------------------------------------------------
package ysyx_22040759_ms_pkg;

  localparam int unsigned EsToMsBusW = 237;
  localparam int unsigned MsToWsBusW = 232;
  localparam int unsigned MsFwdBusW  = 70;

  // Write-back source select codes carried in wreg_sel.
  localparam logic [1:0] WregAlu = 2'd0;
  localparam logic [1:0] WregRam = 2'd1;
  localparam logic [1:0] WregPc  = 2'd2;

  // mem_size encodings.
  localparam logic [1:0] MemSizeB = 2'd0;
  localparam logic [1:0] MemSizeH = 2'd1;
  localparam logic [1:0] MemSizeW = 2'd2;
  localparam logic [1:0] MemSizeD = 2'd3;

  // EX -> MS bundle, [236:0].
  typedef struct packed {
    logic [31:0] inst;          // [236:205]
    logic        reg_wen;       // [204]
    logic [4:0]  rd;            // [203:199]
    logic [1:0]  wreg_sel;      // [198:197]
    logic        mem_re;        // [196]
    logic        mem_we;        // [195]
    logic [1:0]  mem_size;      // [194:193]
    logic        mem_unsigned;  // [192]
    logic [63:0] store_data;    // [191:128]
    logic [63:0] alu_result;    // [127:64]
    logic [63:0] pc;            // [63:0]
  } es_to_ms_t;

  // MS -> WB bundle, [231:0].
  typedef struct packed {
    logic [31:0] inst;          // [231:200]
    logic        reg_wen;       // [199]
    logic [4:0]  rd;            // [198:194]
    logic [1:0]  wreg_sel;      // [193:192]
    logic [63:0] ld_data;       // [191:128]
    logic [63:0] alu_result;    // [127:64]
    logic [63:0] pc;            // [63:0]
  } ms_to_ws_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } ms_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MemSizeB: size_mask = 8'h01;
      MemSizeH: size_mask = 8'h03;
      MemSizeW: size_mask = 8'h0f;
      default:  size_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_fmt.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_lsu_fmt
// Purely combinational load/store data formatting for the MS stage.
// Ports:
//   i_addr_lo     byte offset within the doubleword (addr[2:0])
//   i_size        access size (B/H/W/D)
//   i_unsigned    1 = zero-extend loads, 0 = sign-extend (ignored for D)
//   i_store_data  raw store data, right-aligned
//   i_rdata       doubleword returned by the data bus
//   o_wdata       store data shifted to its byte lane
//   o_wstrb       byte enables shifted to the byte lane; lanes past 7 dropped
//   o_ld_data     load data shifted down, truncated and extended to 64 bits
// ----------------------------------------------------------------------------
module ysyx_22040759_lsu_fmt
  import ysyx_22040759_ms_pkg::*;
(
  input  logic [2:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_ld_data
);

  logic [5:0]  w_bit_shift;
  logic [63:0] w_rshift;

  assign w_bit_shift = {i_addr_lo, 3'b000};
  assign o_wdata     = i_store_data << w_bit_shift;
  // 8-bit shift drops enables that would cross the doubleword.
  assign o_wstrb     = size_mask(i_size) << i_addr_lo;
  assign w_rshift    = i_rdata >> w_bit_shift;

  always_comb begin
    o_ld_data = w_rshift;
    case (i_size)
      MemSizeB: o_ld_data = {{56{~i_unsigned & w_rshift[7]}}, w_rshift[7:0]};
      MemSizeH: o_ld_data = {{48{~i_unsigned & w_rshift[15]}}, w_rshift[15:0]};
      MemSizeW: o_ld_data = {{32{~i_unsigned & w_rshift[31]}}, w_rshift[31:0]};
      default:  o_ld_data = w_rshift;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_ms.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_ms
// Memory-access pipeline stage between EX and WB. Latches the EX bundle,
// runs at most one data-bus transaction per instruction and hands the
// result to WB over a valid/allowin handshake.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   es_to_ms_valid/bus, ms_allowin  EX -> MS handshake and 237-bit bundle
//   ms_to_ws_valid/bus, ws_allowin  MS -> WB handshake and 232-bit bundle
//   data_req_*                      single-outstanding data-bus request
//   data_resp_valid/rdata           one-cycle response (load data or ack)
//   ms_fwd_bus, ms_fwd_stall        only with YSYX_22040759_MS_FWD_EN defined:
//                                   forwarding value and load-use stall to ID
// ----------------------------------------------------------------------------
module ysyx_22040759_ms
  import ysyx_22040759_ms_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  es_to_ms_valid,
  input  logic [EsToMsBusW-1:0] es_to_ms_bus,
  output logic                  ms_allowin,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic [MsToWsBusW-1:0] ms_to_ws_bus,
`ifdef YSYX_22040759_MS_FWD_EN
  output logic [MsFwdBusW-1:0]  ms_fwd_bus,
  output logic                  ms_fwd_stall,
`endif
  output logic                  data_req_valid,
  input  logic                  data_req_ready,
  output logic                  data_req_we,
  output logic [63:0]           data_req_addr,
  output logic [1:0]            data_req_size,
  output logic [63:0]           data_req_wdata,
  output logic [7:0]            data_req_wstrb,
  input  logic                  data_resp_valid,
  input  logic [63:0]           data_resp_rdata
);

  logic      r_ms_valid;
  es_to_ms_t r_bus;
  ms_state_e r_state;
  logic [63:0] r_ld_data;

  es_to_ms_t   w_es;
  ms_to_ws_t   w_ws;
  logic        w_mem_op;
  logic        w_es_mem_op;
  logic        w_ready_go;
  logic        w_accept;
  logic [63:0] w_fmt_wdata;
  logic [7:0]  w_fmt_wstrb;
  logic [63:0] w_fmt_ld;

  assign w_es        = es_to_ms_bus;
  assign w_mem_op    = r_bus.mem_re | r_bus.mem_we;
  assign w_es_mem_op = w_es.mem_re | w_es.mem_we;
  assign w_ready_go  = !w_mem_op || (r_state == StDone);
  assign ms_allowin  = !r_ms_valid || (w_ready_go && ws_allowin);
  assign w_accept    = es_to_ms_valid && ms_allowin;

  assign ms_to_ws_valid = r_ms_valid && w_ready_go;

  ysyx_22040759_lsu_fmt u_lsu_fmt (
    .i_addr_lo    (r_bus.alu_result[2:0]),
    .i_size       (r_bus.mem_size),
    .i_unsigned   (r_bus.mem_unsigned),
    .i_store_data (r_bus.store_data),
    .i_rdata      (data_resp_rdata),
    .o_wdata      (w_fmt_wdata),
    .o_wstrb      (w_fmt_wstrb),
    .o_ld_data    (w_fmt_ld)
  );

  // Request fields come straight from the bundle register, which cannot
  // change while a memory op is outstanding because ms_allowin is low.
  assign data_req_valid = (r_state == StReq);
  assign data_req_we    = r_bus.mem_we;
  assign data_req_addr  = r_bus.alu_result;
  assign data_req_size  = r_bus.mem_size;
  assign data_req_wdata = w_fmt_wdata;
  assign data_req_wstrb = r_bus.mem_we ? w_fmt_wstrb : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms_valid <= 1'b0;
      r_bus      <= '0;
      r_state    <= StIdle;
      r_ld_data  <= '0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_accept) begin
        r_bus <= w_es;
      end
      unique case (r_state)
        // A memory op enters REQ on the same edge it is latched, so the
        // request is visible in the cycle right after acceptance.
        StIdle, StDone: begin
          if (ms_allowin) begin
            r_state <= (w_accept && w_es_mem_op) ? StReq : StIdle;
          end
        end
        StReq: begin
          if (data_req_ready) begin
            r_state <= StResp;
          end
        end
        StResp: begin
          if (data_resp_valid) begin
            if (r_bus.mem_re) begin
              r_ld_data <= w_fmt_ld;
            end
            r_state <= StDone;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_ws            = '0;
    w_ws.inst       = r_bus.inst;
    w_ws.reg_wen    = r_bus.reg_wen;
    w_ws.rd         = r_bus.rd;
    w_ws.wreg_sel   = r_bus.wreg_sel;
    w_ws.ld_data    = r_bus.mem_re ? r_ld_data : 64'd0;
    w_ws.alu_result = r_bus.alu_result;
    w_ws.pc         = r_bus.pc;
  end

  assign ms_to_ws_bus = w_ws;

`ifdef YSYX_22040759_MS_FWD_EN
  assign ms_fwd_bus   = {r_ms_valid && r_bus.reg_wen, r_bus.rd,
                         r_bus.mem_re ? r_ld_data : r_bus.alu_result};
  assign ms_fwd_stall = r_ms_valid && r_bus.mem_re && (r_state != StDone);
`endif

endmodule

// File: tb/tb_ysyx_22040759_ms.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040759_ms
// Directed bench for the MS stage. Expected WB bundles are queued when an
// instruction is issued and popped whenever the DUT transfers to WB.
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_ms;

  logic         clk = 1'b0;
  logic         rst;
  logic         es_to_ms_valid;
  logic [236:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [231:0] ms_to_ws_bus;
  logic         data_req_valid;
  logic         data_req_ready;
  logic         data_req_we;
  logic [63:0]  data_req_addr;
  logic [1:0]   data_req_size;
  logic [63:0]  data_req_wdata;
  logic [7:0]   data_req_wstrb;
  logic         data_resp_valid;
  logic [63:0]  data_resp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  logic [231:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22040759_ms dut (
    .clk             (clk),
    .rst             (rst),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_allowin      (ms_allowin),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_we     (data_req_we),
    .data_req_addr   (data_req_addr),
    .data_req_size   (data_req_size),
    .data_req_wdata  (data_req_wdata),
    .data_req_wstrb  (data_req_wstrb),
    .data_resp_valid (data_resp_valid),
    .data_resp_rdata (data_resp_rdata)
  );

  always @(posedge clk) begin
    if (data_req_valid && data_req_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [231:0] obs, input logic [231:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [236:0] mk_es(input logic [31:0] inst, input logic [4:0] rd,
                                         input logic re, input logic we, input logic [1:0] size,
                                         input logic uns, input logic [63:0] sdata,
                                         input logic [63:0] alu, input logic [63:0] pc);
    logic [1:0] wsel;
    wsel = re ? 2'd1 : 2'd0;
    return {inst, 1'b1, rd, wsel, re, we, size, uns, sdata, alu, pc};
  endfunction

  // WB bundle: upper 40 bits of the EX bundle, load data, then alu_result and pc.
  function automatic logic [231:0] mk_ws(input logic [236:0] es, input logic [63:0] ld);
    return {es[236:197], ld, es[127:0]};
  endfunction

  // Check any WB transfer happening this cycle, then advance one clock.
  task automatic tick();
    if (ms_to_ws_valid && ws_allowin) begin
      chk("xfer_expected", 232'(exp_q.size() != 0), 232'd1);
      if (exp_q.size() != 0) chk("ws_bus", ms_to_ws_bus, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [236:0] es);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es;
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  // Runs a load up to DONE with one-cycle ready and response.
  task automatic load_txn(input string tag, input logic [236:0] es, input logic [63:0] rdata,
                          input logic [63:0] ld_exp);
    int h0;
    exp_q.push_back(mk_ws(es, ld_exp));
    h0 = hs_cnt;
    issue(es);
    chk({tag, "_req_valid"}, data_req_valid, 1'b1);
    chk({tag, "_req_we"}, data_req_we, 1'b0);
    chk({tag, "_req_addr"}, data_req_addr, es[127:64]);
    chk({tag, "_req_size"}, data_req_size, es[194:193]);
    chk({tag, "_req_wstrb"}, data_req_wstrb, 8'h00);
    data_req_ready = 1'b1;
    tick();
    data_req_ready = 1'b0;
    chk({tag, "_wait_resp"}, ms_to_ws_valid, 1'b0);
    data_resp_valid = 1'b1;
    data_resp_rdata = rdata;
    tick();
    data_resp_valid = 1'b0;
    chk({tag, "_done_valid"}, ms_to_ws_valid, 1'b1);
    chk({tag, "_one_hs"}, hs_cnt - h0, 1);
  endtask

  initial begin
    logic [236:0] es;
    logic [236:0] es2;
    int h0;
    rst             = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    ws_allowin      = 1'b1;
    data_req_ready  = 1'b0;
    data_resp_valid = 1'b0;
    data_resp_rdata = '0;
    tick();
    tick();
    chk("rst_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_req_valid", data_req_valid, 1'b0);
    chk("rst_allowin", ms_allowin, 1'b1);
    rst = 1'b0;
    tick();

    // ALU op: one-cycle latency, no data request.
    es = mk_es(32'h0000_0013, 5'd1, 1'b0, 1'b0, 2'd3, 1'b0, 64'h0, 64'h1234, 64'h8000_0000);
    exp_q.push_back(mk_ws(es, 64'h0));
    issue(es);
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_noreq", data_req_valid, 1'b0);
    chk("alu_result", ms_to_ws_bus[127:64], 64'h1234);
    tick();
    chk("alu_drained", ms_to_ws_valid, 1'b0);

    // lb / lbu of byte 3 = 0x80.
    es = mk_es(32'h0030_0083, 5'd2, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0, 64'h8000_1003, 64'h8000_0004);
    load_txn("lb", es, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    es = mk_es(32'h0030_4083, 5'd3, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0, 64'h8000_1003, 64'h8000_0008);
    load_txn("lbu", es, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
    tick();

    // sh at offset 6 with ready held low for 3 cycles.
    es = mk_es(32'h00F0_1323, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 64'hBEEF, 64'h8000_1006,
               64'h8000_000C);
    exp_q.push_back(mk_ws(es, 64'h0));
    h0 = hs_cnt;
    issue(es);
    for (int i = 0; i < 4; i++) begin
      chk("sh_req_valid", data_req_valid, 1'b1);
      chk("sh_we", data_req_we, 1'b1);
      chk("sh_addr", data_req_addr, 64'h8000_1006);
      chk("sh_wdata", data_req_wdata, 64'hBEEF_0000_0000_0000);
      chk("sh_wstrb", data_req_wstrb, 8'hC0);
      chk("sh_size", data_req_size, 2'd1);
      chk("sh_allowin", ms_allowin, 1'b0);
      if (i < 3) tick();
    end
    data_req_ready = 1'b1;
    tick();
    data_req_ready = 1'b0;
    tick();
    chk("sh_wait_ack", ms_to_ws_valid, 1'b0);
    data_resp_valid = 1'b1;
    tick();
    data_resp_valid = 1'b0;
    chk("sh_done", ms_to_ws_valid, 1'b1);
    chk("sh_one_hs", hs_cnt - h0, 1);
    tick();

    // ld completes while WB stalls for 4 cycles, then lw follows back-to-back.
    ws_allowin = 1'b0;
    es = mk_es(32'h0080_3403, 5'd8, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h8000_1008, 64'h8000_0010);
    load_txn("ld", es, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", ms_to_ws_valid, 1'b1);
      chk("stall_bus", ms_to_ws_bus, mk_ws(es, 64'h1122_3344_5566_7788));
      chk("stall_allowin", ms_allowin, 1'b0);
      tick();
    end
    ws_allowin = 1'b1;
    es2 = mk_es(32'h0040_2483, 5'd9, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'h8000_1004,
                64'h8000_0014);
    exp_q.push_back(mk_ws(es2, 64'hFFFF_FFFF_8000_0001));
    issue(es2);
    chk("lw_b2b_req", data_req_valid, 1'b1);
    chk("lw_b2b_nowsvalid", ms_to_ws_valid, 1'b0);
    data_req_ready = 1'b1;
    tick();
    data_req_ready = 1'b0;
    data_resp_valid = 1'b1;
    data_resp_rdata = 64'h8000_0001_0000_0000;
    tick();
    data_resp_valid = 1'b0;
    chk("lw_done", ms_to_ws_valid, 1'b1);
    tick();
    chk("lw_drained", ms_to_ws_valid, 1'b0);

    // Reset while waiting for a response; the late response is dropped.
    es = mk_es(32'h0000_2503, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'h8000_2000,
               64'h8000_0018);
    issue(es);
    data_req_ready = 1'b1;
    tick();
    data_req_ready = 1'b0;
    chk("rr_in_resp", data_req_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rr_allowin", ms_allowin, 1'b1);
    chk("rr_req_valid", data_req_valid, 1'b0);
    data_resp_valid = 1'b1;
    data_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    data_resp_valid = 1'b0;
    chk("rr_late_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rr_late_req", data_req_valid, 1'b0);
    chk("rr_late_allowin", ms_allowin, 1'b1);

    // Pipeline still works after the flush.
    es = mk_es(32'h0010_0093, 5'd11, 1'b0, 1'b0, 2'd3, 1'b0, 64'h0, 64'h5A5A, 64'h8000_001C);
    exp_q.push_back(mk_ws(es, 64'h0));
    issue(es);
    chk("post_valid", ms_to_ws_valid, 1'b1);
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
